// File: rtl/lsu_ctrl_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds funct3 codes, FSM states and byte/half lane accessors.
package lsu_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RESP,
        ERR
    } state_t;

    function automatic logic [7:0] get_byte(
        input logic [31:0] w,
        input logic [1:0]  sel
    );
        logic [7:0] r;
        r = w[7:0];
        case (sel)
            2'd0: r = w[7:0];
            2'd1: r = w[15:8];
            2'd2: r = w[23:16];
            2'd3: r = w[31:24];
            default: r = w[7:0];
        endcase
        return r;
    endfunction

    function automatic logic [31:0] put_byte(
        input logic [31:0] w,
        input logic [1:0]  sel,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = w;
        case (sel)
            2'd0: r[7:0]   = b;
            2'd1: r[15:8]  = b;
            2'd2: r[23:16] = b;
            2'd3: r[31:24] = b;
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] get_half(
        input logic [31:0] w,
        input logic        hi
    );
        return hi ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] put_half(
        input logic [31:0] w,
        input logic        hi,
        input logic [15:0] h
    );
        return hi ? {h, w[15:0]} : {w[31:16], h};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend, store merge,
// and alignment check for one access.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [15:0]     wdata,
    input  logic [1:0]      sel,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_val,
    output logic [XLEN-1:0] merged,
    output logic            misalign
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b        = get_byte(rdata, sel);
        h        = get_half(rdata, sel[1]);
        load_val = '0;
        merged   = rdata;
        misalign = 1'b0;
        case (funct3)
            F3_B: begin
                load_val = {{24{b[7]}}, b};
                merged   = put_byte(rdata, sel, wdata[7:0]);
            end
            F3_BU: begin
                load_val = {24'b0, b};
            end
            F3_H: begin
                load_val = {{16{h[15]}}, h};
                merged   = put_half(rdata, sel[1], wdata);
                misalign = sel[0];
            end
            F3_HU: begin
                load_val = {16'b0, h};
                misalign = sel[0];
            end
            F3_W: begin
                load_val = rdata;
                misalign = |sel;
            end
            default: begin
                load_val = '0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: byte-addressed requests in, word-indexed
// dmem accesses out, with read-modify-write for sub-word stores.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int n  = 32,
    parameter int AW = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    output logic         resp_valid,
    output logic [n-1:0] resp_rdata,
    output logic         resp_err,
    output logic [n-1:0] mem_addr,
    output logic         mem_we,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata
);

    state_t state;
    state_t state_nx;

    logic          we_q;
    logic [2:0]    f3_q;
    logic [AW+1:0] addr_q;
    logic [15:0]   wdata_q;

    logic          idle;
    logic          accept;
    logic [1:0]    a_sel;
    logic [2:0]    a_f3;
    logic [n-1:0]  load_val;
    logic [n-1:0]  merged;
    logic          misalign;
    logic          f3_ok;
    logic          range_ok;
    logic          req_bad;

    assign idle   = (state == IDLE);
    assign accept = req_valid & idle;

    // In IDLE the aligner judges the incoming request; later it
    // works on the latched copy.
    assign a_sel = idle ? req_addr[1:0] : addr_q[1:0];
    assign a_f3  = idle ? req_funct3 : f3_q;

    lsu_align u_align (
        .rdata    (mem_rdata),
        .wdata    (wdata_q),
        .sel      (a_sel),
        .funct3   (a_f3),
        .load_val (load_val),
        .merged   (merged),
        .misalign (misalign)
    );

    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = ~req_we;
            default:          f3_ok = 1'b0;
        endcase
    end

    assign range_ok = ~|req_addr[n-1:AW+2];
    assign req_bad  = ~f3_ok | misalign | ~range_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_bad) begin
                        state_nx = ERR;
                    end else if (req_we && req_funct3 == F3_W) begin
                        state_nx = WR;
                    end else begin
                        state_nx = RD;
                    end
                end
            end
            RD: begin
                mem_addr = {{(n-AW){1'b0}}, addr_q[AW+1:2]};
                state_nx = we_q ? WR : RESP;
            end
            WR: begin
                mem_addr = {{(n-AW){1'b0}}, addr_q[AW+1:2]};
                mem_we   = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            mem_wdata  <= '0;
        end else if (accept) begin
            we_q       <= req_we;
            f3_q       <= req_funct3;
            addr_q     <= req_addr[AW+1:0];
            wdata_q    <= req_wdata[15:0];
            resp_rdata <= '0;
            if (req_we) begin
                mem_wdata <= req_wdata;
            end
        end else if (state == RD) begin
            if (we_q) begin
                mem_wdata <= merged;
            end else begin
                resp_rdata <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus random
// traffic against an arithmetic byte-lane memory model.
module tb_lsu_ctrl;

    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] dmem [DEPTH];
    logic [31:0] exp_mem [DEPTH];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rd;
        bit        err;
        int        lat;
    } dir_t;

    lsu_ctrl #(.n(32), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr[AW-1:0]];

    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr[AW-1:0]] <= mem_wdata;
    end

    // Reference: RV32I load/store semantics on a little-endian
    // word array, updated only for legal stores.
    function automatic void model(
        input bit we, input bit [2:0] f3,
        input bit [31:0] addr, input bit [31:0] wdata,
        output bit [31:0] rd, output bit e, output int lat
    );
        bit legal;
        int size;
        int sh;
        bit [31:0] word;
        bit [31:0] mask;
        bit [31:0] v;
        legal = we ? (f3 <= 3'd2)
                   : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e = !legal || (addr % size) != 0 || addr >= 4 * DEPTH;
        rd = 0;
        if (e) begin
            lat = 1;
            return;
        end
        word = exp_mem[addr / 4];
        sh = 8 * (addr % 4);
        mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!we) begin
            lat = 2;
            v = (word >> sh) & mask;
            if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            rd = v;
        end else begin
            lat = (size == 4) ? 2 : 3;
            exp_mem[addr / 4] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
        end
    endfunction

    task automatic do_req(
        input bit we, input bit [2:0] f3,
        input bit [31:0] addr, input bit [31:0] wdata,
        output bit [31:0] rd, output bit e, output int lat,
        output int pulses, output bit [31:0] waddr, output bit [31:0] wval
    );
        lat = 0;
        pulses = 0;
        rd = 0;
        e = 0;
        waddr = 0;
        wval = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wdata;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_req: got %b want 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_we) begin
                pulses++;
                waddr = mem_addr;
                wval = mem_wdata;
            end
            if (resp_valid) begin
                lat = k;
                rd = resp_rdata;
                e = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 1000",
                     {req_ready, resp_valid, resp_err, mem_we});
        end
        checks++;
        if (resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0", resp_rdata);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: got addr %h wdata %h want 0 0",
                     mem_addr, mem_wdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_and_subword;
        dir_t t [4];
        bit [31:0] rd, waddr, wval, mrd;
        bit e, me;
        int lat, pulses, mlat;
        t[0] = '{1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2};
        t[1] = '{0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2};
        t[2] = '{1, 3'd0, 32'h11, 32'h1234565A, 32'h0, 0, 3};
        t[3] = '{0, 3'd2, 32'h10, 32'h0, 32'hDEAD5AEF, 0, 2};
        foreach (t[i]) begin
            do_req(t[i].we, t[i].f3, t[i].addr, t[i].wdata,
                   rd, e, lat, pulses, waddr, wval);
            model(t[i].we, t[i].f3, t[i].addr, t[i].wdata, mrd, me, mlat);
            checks++;
            if (lat !== t[i].lat) begin
                errors++;
                $display("FAIL word_sub[%0d] latency: got %0d want %0d",
                         i, lat, t[i].lat);
            end
            checks++;
            if (e !== t[i].err || rd !== t[i].rd) begin
                errors++;
                $display("FAIL word_sub[%0d] resp: got err %b data %h want %b %h",
                         i, e, rd, t[i].err, t[i].rd);
            end
            checks++;
            if (pulses !== (t[i].we ? 1 : 0)) begin
                errors++;
                $display("FAIL word_sub[%0d] we_pulses: got %0d want %0d",
                         i, pulses, t[i].we ? 1 : 0);
            end
            if (t[i].we) begin
                checks++;
                if (waddr !== t[i].addr >> 2 || wval !== exp_mem[t[i].addr >> 2]) begin
                    errors++;
                    $display("FAIL word_sub[%0d] write: got %h:%h want %h:%h",
                             i, waddr, wval, t[i].addr >> 2, exp_mem[t[i].addr >> 2]);
                end
            end
        end
    endtask

    task automatic test_sign_ext;
        dir_t t [5];
        bit [31:0] rd, waddr, wval, mrd;
        bit e, me;
        int lat, pulses, mlat;
        t[0] = '{1, 3'd2, 32'h20, 32'h8000F080, 32'h0, 0, 2};
        t[1] = '{0, 3'd0, 32'h20, 32'h0, 32'hFFFFFF80, 0, 2};
        t[2] = '{0, 3'd4, 32'h20, 32'h0, 32'h00000080, 0, 2};
        t[3] = '{0, 3'd1, 32'h22, 32'h0, 32'hFFFF8000, 0, 2};
        t[4] = '{0, 3'd5, 32'h22, 32'h0, 32'h00008000, 0, 2};
        foreach (t[i]) begin
            do_req(t[i].we, t[i].f3, t[i].addr, t[i].wdata,
                   rd, e, lat, pulses, waddr, wval);
            model(t[i].we, t[i].f3, t[i].addr, t[i].wdata, mrd, me, mlat);
            checks++;
            if (lat !== t[i].lat || e !== t[i].err || rd !== t[i].rd) begin
                errors++;
                $display("FAIL sign_ext[%0d]: got lat %0d err %b data %h want %0d %b %h",
                         i, lat, e, rd, t[i].lat, t[i].err, t[i].rd);
            end
        end
    endtask

    task automatic test_errors;
        dir_t t [5];
        bit [31:0] rd, waddr, wval, mrd;
        bit e, me;
        int lat, pulses, mlat;
        t[0] = '{0, 3'd2, 32'h13, 32'h0, 32'h0, 1, 1};
        t[1] = '{1, 3'd1, 32'h21, 32'hFFFF, 32'h0, 1, 1};
        t[2] = '{0, 3'd3, 32'h10, 32'h0, 32'h0, 1, 1};
        t[3] = '{0, 3'd2, 32'h1000, 32'h0, 32'h0, 1, 1};
        t[4] = '{1, 3'd4, 32'h10, 32'h77, 32'h0, 1, 1};
        foreach (t[i]) begin
            do_req(t[i].we, t[i].f3, t[i].addr, t[i].wdata,
                   rd, e, lat, pulses, waddr, wval);
            model(t[i].we, t[i].f3, t[i].addr, t[i].wdata, mrd, me, mlat);
            checks++;
            if (lat !== t[i].lat || e !== 1'b1 || rd !== 32'h0) begin
                errors++;
                $display("FAIL err[%0d]: got lat %0d err %b data %h want 1 1 0",
                         i, lat, e, rd);
            end
            checks++;
            if (pulses !== 0) begin
                errors++;
                $display("FAIL err[%0d] we_pulses: got %0d want 0", i, pulses);
            end
        end
    endtask

    task automatic test_reset_rmw;
        bit [31:0] rd, waddr, wval, mrd;
        bit e, me;
        int lat, pulses, mlat;
        int we_seen;
        do_req(1, 3'd2, 32'h30, 32'h11223344, rd, e, lat, pulses, waddr, wval);
        model(1, 3'd2, 32'h30, 32'h11223344, mrd, me, mlat);
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'd0;
        req_addr = 32'h31;
        req_wdata = 32'hAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        checks++;
        if (mem_addr !== 32'hC || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rmw_rd_phase: got addr %h we %b want c 0", mem_addr, mem_we);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmw_reset_now: got we %b ready %b rv %b want 0 1 0",
                     mem_we, req_ready, resp_valid);
        end
        we_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_we) we_seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_we) we_seen++;
        end
        checks++;
        if (we_seen !== 0) begin
            errors++;
            $display("FAIL rmw_no_write: got %0d pulses want 0", we_seen);
        end
        checks++;
        if (dmem[12] !== exp_mem[12]) begin
            errors++;
            $display("FAIL rmw_mem_kept: got %h want %h", dmem[12], exp_mem[12]);
        end
        do_req(0, 3'd2, 32'h30, 32'h0, rd, e, lat, pulses, waddr, wval);
        checks++;
        if (rd !== 32'h11223344 || e !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL rmw_readback: got %h err %b lat %0d want 11223344 0 2",
                     rd, e, lat);
        end
    endtask

    task automatic test_handshake;
        bit [31:0] addrs [3];
        bit [31:0] exp_q [$];
        bit [31:0] got_q [$];
        bit [31:0] mrd;
        bit me, acc, spacing_ok;
        int mlat, sent, last_acc, cyc, extra;
        addrs[0] = 32'h10;
        addrs[1] = 32'h20;
        addrs[2] = 32'h30;
        foreach (addrs[i]) begin
            model(0, 3'd2, addrs[i], 32'h0, mrd, me, mlat);
            exp_q.push_back(mrd);
        end
        sent = 0;
        last_acc = -1;
        cyc = 0;
        spacing_ok = 1;
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = 3'd2;
        req_addr = addrs[0];
        req_wdata = $urandom;
        while (cyc < 40 && got_q.size() < 3) begin
            if (resp_valid) got_q.push_back(resp_rdata);
            acc = req_valid && req_ready;
            if (acc) begin
                if (last_acc >= 0 && cyc - last_acc != 3) spacing_ok = 0;
                last_acc = cyc;
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (sent < 3) req_addr = addrs[sent];
                else req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid) extra++;
        end
        checks++;
        if (got_q.size() !== 3 || extra !== 0 || sent !== 3) begin
            errors++;
            $display("FAIL hs_count: got %0d resp +%0d extra, %0d accepts want 3 +0, 3",
                     got_q.size(), extra, sent);
        end
        checks++;
        if (!spacing_ok) begin
            errors++;
            $display("FAIL hs_spacing: got non-3-cycle accept spacing want 3");
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL hs_data[%0d]: got %h want %h",
                         i, (i < got_q.size()) ? got_q[i] : 32'hX, exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        bit [31:0] rd, waddr, wval, mrd, addr, wdata;
        bit e, me, we;
        bit [2:0] f3;
        int lat, pulses, mlat, ep, bad, r;
        for (int i = 0; i < 80; i++) begin
            we = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            f3 = (r == 0) ? 3'($urandom_range(0, 7))
               : we ? 3'($urandom_range(0, 2))
               : 3'(r % 6 == 3 ? 4 : r % 6);
            r = $urandom_range(0, 9);
            addr = (r == 0) ? 32'h1000 + $urandom_range(0, 255)
                 : (r == 1) ? 32'hFF0 + $urandom_range(0, 15)
                 : $urandom_range(0, 127);
            wdata = $urandom;
            do_req(we, f3, addr, wdata, rd, e, lat, pulses, waddr, wval);
            model(we, f3, addr, wdata, mrd, me, mlat);
            ep = (we && !me) ? 1 : 0;
            checks++;
            if (lat !== mlat || e !== me || rd !== mrd) begin
                errors++;
                $display("FAIL rand[%0d] we%b f3=%0d a=%h: got lat %0d err %b data %h want %0d %b %h",
                         i, we, f3, addr, lat, e, rd, mlat, me, mrd);
            end
            checks++;
            if (pulses !== ep || (ep == 1 && waddr !== addr >> 2)) begin
                errors++;
                $display("FAIL rand[%0d] write: got %0d pulses at %h want %0d at %h",
                         i, pulses, waddr, ep, addr >> 2);
            end
        end
        @(negedge clk);
        bad = 0;
        for (int w = 0; w < DEPTH; w++) begin
            if (dmem[w] !== exp_mem[w]) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rand_mem_image: got %0d differing words want 0", bad);
        end
    endtask

    initial begin
        for (int w = 0; w < DEPTH; w++) begin
            dmem[w] = 32'h0;
            exp_mem[w] = 32'h0;
        end
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        test_reset();
        test_word_and_subword();
        test_sign_ext();
        test_errors();
        test_reset_rmw();
        test_handshake();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
